// File: rtl/cnn_pkg.sv
// cnn_pkg: shared defaults, pixel type, pooling FSM states and a width helper
package cnn_pkg;
  localparam int WORD_SIZE_DEF = 8;
  localparam int ROW_SIZE_DEF = 540;
  localparam int IMAGE_HEIGHT_DEF = 360;
  typedef logic [WORD_SIZE_DEF-1:0] pixel_t;
  typedef enum logic {S_EVEN_ROW, S_ODD_ROW} pool_state_t;
  function automatic int clog2_min1(input int v);
    return v < 2 ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/pool_line_buffer.sv
// pool_line_buffer: DEPTH x WORD_SIZE memory, one write port, one registered read port (clk, rst, wr_en/wr_addr/wr_data, rd_en/rd_addr -> rd_data)
module pool_line_buffer #(
  parameter int WORD_SIZE = 8,
  parameter int DEPTH = 270,
  parameter int AW = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_addr,
  output logic [WORD_SIZE-1:0] rd_data
);
  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic [WORD_SIZE-1:0] rd_data_q, rd_data_d;
  always_ff @(posedge clk) if (wr_en) mem[wr_addr] <= wr_data;
  // read data only moves on a read so it survives input gaps
  always_comb rd_data_d = rd_en ? mem[rd_addr] : rd_data_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) rd_data_q <= '0;
    else rd_data_q <= rd_data_d;
  assign rd_data = rd_data_q;
endmodule

// File: rtl/max_pool_stream.sv
// max_pool_stream: 2x2 stride-2 max pooling over a raster pixel stream (clk, rst async high, inValid/inputPixel in, outValid/outputPixel out; frameDone when MAX_POOL_FRAME_DONE_EN)
module max_pool_stream
  import cnn_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int ROW_SIZE = ROW_SIZE_DEF,
  parameter int IMAGE_HEIGHT = IMAGE_HEIGHT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inValid,
  input  logic [WORD_SIZE-1:0] inputPixel,
  output logic                 outValid,
  output logic [WORD_SIZE-1:0] outputPixel
`ifdef MAX_POOL_FRAME_DONE_EN
  ,
  output logic                 frameDone
`endif
);
  localparam int CW = clog2_min1(ROW_SIZE);
  localparam int RW = clog2_min1(IMAGE_HEIGHT);
  localparam int DEPTH = ROW_SIZE / 2;
  localparam int AW = clog2_min1(DEPTH);
  if (ROW_SIZE < 2 || ROW_SIZE % 2 != 0 || IMAGE_HEIGHT < 2 || IMAGE_HEIGHT % 2 != 0) begin : g_bad_size
    $error("max_pool_stream: ROW_SIZE and IMAGE_HEIGHT must be even and at least 2");
  end
  function automatic logic [WORD_SIZE-1:0] pmax(input logic [WORD_SIZE-1:0] a, input logic [WORD_SIZE-1:0] b);
    return a > b ? a : b;
  endfunction
  pool_state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [WORD_SIZE-1:0] held_q, held_d, out_pixel_q, out_pixel_d, rd_data;
  logic out_valid_q, out_valid_d;
  logic last_col, last_row, wr_en, rd_en, fire;
  logic [AW-1:0] addr;
  always_comb begin
    last_col = col_q == CW'(ROW_SIZE - 1);
    last_row = row_q == RW'(IMAGE_HEIGHT - 1);
    addr = AW'(col_q >> 1);
    col_d = inValid ? (last_col ? '0 : col_q + CW'(1)) : col_q;
    row_d = inValid && last_col ? (last_row ? '0 : row_q + RW'(1)) : row_q;
    state_d = inValid && last_col ? (state_q == S_EVEN_ROW ? S_ODD_ROW : S_EVEN_ROW) : state_q;
    held_d = inValid && !col_q[0] ? inputPixel : held_q;
    wr_en = inValid && state_q == S_EVEN_ROW && col_q[0];
    rd_en = inValid && state_q == S_ODD_ROW && !col_q[0];
    fire = inValid && state_q == S_ODD_ROW && col_q[0];
    out_valid_d = fire;
    out_pixel_d = fire ? pmax(pmax(held_q, inputPixel), rd_data) : out_pixel_q;
  end
  pool_line_buffer #(.WORD_SIZE(WORD_SIZE), .DEPTH(DEPTH), .AW(AW)) u_lb (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_addr(addr),
    .wr_data(pmax(held_q, inputPixel)),
    .rd_en(rd_en),
    .rd_addr(addr),
    .rd_data(rd_data)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_EVEN_ROW;
      col_q <= '0;
      row_q <= '0;
      held_q <= '0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      held_q <= held_d;
      out_valid_q <= out_valid_d;
      out_pixel_q <= out_pixel_d;
    end
  assign outValid = out_valid_q;
  assign outputPixel = out_pixel_q;
`ifdef MAX_POOL_FRAME_DONE_EN
  logic frame_done_q, frame_done_d;
  always_comb frame_done_d = fire && last_col && last_row;
  always_ff @(posedge clk or posedge rst)
    if (rst) frame_done_q <= 1'b0;
    else frame_done_q <= frame_done_d;
  assign frameDone = frame_done_q;
`endif
endmodule

// File: tb/tb_max_pool_stream.sv
// tb_max_pool_stream: scoreboard bench for max_pool_stream on a 4x2 and a 4x4 instance
module tb_max_pool_stream;
  typedef struct {
    logic [7:0] px;
    logic fd;
  } exp_t;
  logic clk = 0, rst_a = 1, rst_b = 1;
  logic in_a_v = 0, in_b_v = 0, ov_a, ov_b, fd_a, fd_b, acc_a = 0, acc_b = 0;
  logic [7:0] in_a_p = 0, in_b_p = 0, op_a, op_b, last_a = 0, last_b = 0;
  exp_t q_a[$], q_b[$];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  max_pool_stream #(.WORD_SIZE(8), .ROW_SIZE(4), .IMAGE_HEIGHT(2)) dut_a (
    .clk(clk), .rst(rst_a), .inValid(in_a_v), .inputPixel(in_a_p), .outValid(ov_a), .outputPixel(op_a)
`ifdef MAX_POOL_FRAME_DONE_EN
    , .frameDone(fd_a)
`endif
  );
  max_pool_stream #(.WORD_SIZE(8), .ROW_SIZE(4), .IMAGE_HEIGHT(4)) dut_b (
    .clk(clk), .rst(rst_b), .inValid(in_b_v), .inputPixel(in_b_p), .outValid(ov_b), .outputPixel(op_b)
`ifdef MAX_POOL_FRAME_DONE_EN
    , .frameDone(fd_b)
`endif
  );
`ifndef MAX_POOL_FRAME_DONE_EN
  assign fd_a = 1'b0;
  assign fd_b = 1'b0;
`endif
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", n, got, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    acc_a <= in_a_v;
    acc_b <= in_b_v;
  end
  always @(negedge clk) begin
    exp_t e;
    if (rst_a) last_a = 0;
    else if (ov_a) begin
      chk("a_expected_output_present", 32'(q_a.size() > 0), 1);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        chk("a_pixel", 32'(op_a), 32'(e.px));
        chk("a_latency", 32'(acc_a), 1);
`ifdef MAX_POOL_FRAME_DONE_EN
        chk("a_frame_done", 32'(fd_a), 32'(e.fd));
`endif
        last_a = e.px;
      end
    end else begin
      chk("a_hold", 32'(op_a), 32'(last_a));
`ifdef MAX_POOL_FRAME_DONE_EN
      chk("a_frame_done_idle", 32'(fd_a), 0);
`endif
    end
    if (rst_b) last_b = 0;
    else if (ov_b) begin
      chk("b_expected_output_present", 32'(q_b.size() > 0), 1);
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        chk("b_pixel", 32'(op_b), 32'(e.px));
        chk("b_latency", 32'(acc_b), 1);
`ifdef MAX_POOL_FRAME_DONE_EN
        chk("b_frame_done", 32'(fd_b), 32'(e.fd));
`endif
        last_b = e.px;
      end
    end else begin
      chk("b_hold", 32'(op_b), 32'(last_b));
`ifdef MAX_POOL_FRAME_DONE_EN
      chk("b_frame_done_idle", 32'(fd_b), 0);
`endif
    end
  end
  task automatic push_a(input logic [7:0] px, input logic fd);
    exp_t e;
    e.px = px;
    e.fd = fd;
    q_a.push_back(e);
  endtask
  task automatic push_b(input logic [7:0] px, input logic fd);
    exp_t e;
    e.px = px;
    e.fd = fd;
    q_b.push_back(e);
  endtask
  task automatic send_a(input logic [7:0] p, input int gap);
    in_a_v = 1;
    in_a_p = p;
    @(posedge clk) #1;
    in_a_v = 0;
    repeat (gap) @(posedge clk) #1;
  endtask
  task automatic send_b(input logic [7:0] p, input int gap);
    in_b_v = 1;
    in_b_p = p;
    @(posedge clk) #1;
    in_b_v = 0;
    repeat (gap) @(posedge clk) #1;
  endtask
  initial begin
    logic [7:0] img[16];
    logic [7:0] m;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_a_out_valid", 32'(ov_a), 0);
    chk("reset_a_out_pixel", 32'(op_a), 0);
    chk("reset_b_out_valid", 32'(ov_b), 0);
    chk("reset_b_out_pixel", 32'(op_b), 0);
`ifdef MAX_POOL_FRAME_DONE_EN
    chk("reset_a_frame_done", 32'(fd_a), 0);
`endif
    rst_a = 0;
    rst_b = 0;
    @(posedge clk) #1;
    push_a(8'd6, 0);
    push_a(8'd8, 1);
    for (int i = 1; i <= 8; i++) send_a(8'(i), 0);
    push_a(8'hFF, 0);
    push_a(8'h00, 1);
    for (int i = 0; i < 8; i++) send_a(i == 4 ? 8'hFF : 8'h00, 0);
    push_a(8'd6, 0);
    push_a(8'd8, 1);
    for (int i = 1; i <= 8; i++) send_a(8'(i), 3);
    push_a(8'd6, 0);
    push_a(8'd8, 1);
    push_a(8'h10, 0);
    push_a(8'h10, 1);
    for (int i = 1; i <= 8; i++) send_a(8'(i), 0);
    for (int i = 0; i < 8; i++) send_a(8'h10, 0);
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
      if (f == 0) begin
        img[0] = 8'h80;
        img[1] = 8'h7F;
        img[4] = 8'h01;
        img[5] = 8'h00;
      end
      for (int r = 0; r < 4; r += 2)
        for (int c = 0; c < 4; c += 2) begin
          m = img[r*4+c];
          if (img[r*4+c+1] > m) m = img[r*4+c+1];
          if (img[r*4+c+4] > m) m = img[r*4+c+4];
          if (img[r*4+c+5] > m) m = img[r*4+c+5];
          push_b(m, r == 2 && c == 2);
        end
      for (int i = 0; i < 16; i++) send_b(img[i], int'($urandom_range(0, 2)));
    end
    for (int i = 0; i < 5; i++) send_b(8'(i), 0);
    rst_b = 1;
    @(posedge clk) #1;
    chk("midreset_b_out_valid", 32'(ov_b), 0);
    chk("midreset_b_out_pixel", 32'(op_b), 0);
    @(posedge clk) #1;
    rst_b = 0;
    @(posedge clk) #1;
    push_b(8'd5, 0);
    push_b(8'd7, 0);
    push_b(8'd13, 0);
    push_b(8'd15, 1);
    for (int i = 0; i < 16; i++) send_b(8'(i), 0);
    for (int i = 0; i < 50 && (q_a.size() > 0 || q_b.size() > 0); i++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    chk("drain_a", 32'(q_a.size()), 0);
    chk("drain_b", 32'(q_b.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
